// File: rtl/sys_types.sv
// Shared types for the tensor RAM writer: FIFO entry layout and completion FSM states.
package sys_types;

    localparam int unsigned TRW_N_BITS   = 6;
    localparam int unsigned TRW_CH_BITS  = 7;
    localparam int unsigned TRW_IDX_BITS = 6;

    typedef struct packed {
        logic [7:0]              data;
        logic [TRW_N_BITS-1:0]   row;
        logic [TRW_N_BITS-1:0]   col;
        logic [TRW_IDX_BITS-1:0] index;
        logic                    bypass;
        logic [TRW_CH_BITS-1:0]  channel;
    } trw_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StDone
    } trw_done_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, no fall-through; a push when full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int unsigned PTR_BITS   = $clog2(DEPTH);
    localparam int unsigned COUNT_BITS = $clog2(DEPTH+1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [COUNT_BITS-1:0] r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == COUNT_BITS'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + COUNT_BITS'(w_do_push) - COUNT_BITS'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/tensor_ram_writer.sv
// Buffers the STA output stream and issues byte-enabled tensor RAM writes.
// Define TRW_OVERFLOW_CHECK_EN to enable sticky overflow and conv range checking.
module tensor_ram_writer
    import sys_types::*;
#(
    parameter int unsigned MAX_N          = 64,
    parameter int unsigned MAX_NUM_CH     = 64,
    parameter int unsigned MAX_BYPASS_IDX = 64,
    parameter int unsigned ADDR_BITS      = 16,
    parameter int unsigned FIFO_DEPTH     = 8,
    localparam int unsigned N_BITS          = $clog2(MAX_N),
    localparam int unsigned CH_BITS         = $clog2(MAX_NUM_CH+1),
    localparam int unsigned BYPASS_IDX_BITS = $clog2(MAX_BYPASS_IDX)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    input  logic [N_BITS-1:0]          in_row,
    input  logic [N_BITS-1:0]          in_col,
    input  logic [BYPASS_IDX_BITS-1:0] in_index,
    input  logic                       bypass_mode,
    input  logic [N_BITS:0]            out_width,
    input  logic [CH_BITS-1:0]         num_channels,
    input  logic [CH_BITS-1:0]         cur_channel,
    input  logic [ADDR_BITS-1:0]       base_addr,
    input  logic                       layer_done,
    output logic                       ram_we,
    input  logic                       ram_ready,
    output logic [ADDR_BITS-1:0]       ram_addr,
    output logic [31:0]                ram_wdata,
    output logic [3:0]                 ram_be,
    output logic                       idle,
    output logic                       write_done,
    output logic                       overflow
);
    trw_entry_t                        w_push_entry;
    trw_entry_t                        w_head;
    trw_entry_t                        r_a_entry;
    logic                              w_push_ok;
    logic                              w_pop;
    logic                              w_fifo_full;
    logic                              w_fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   w_fifo_count;
    logic                              r_a_valid;
    logic [ADDR_BITS-1:0]              r_a_pix;
    logic                              w_out_free;
    logic                              w_a_adv;
    logic [ADDR_BITS-1:0]              w_addr;
    logic [3:0]                        w_be;
    logic                              r_ram_we;
    logic [ADDR_BITS-1:0]              r_ram_addr;
    logic [31:0]                       r_ram_wdata;
    logic [3:0]                        r_ram_be;
    logic                              w_drained;
    trw_done_state_e                   r_state;
    trw_done_state_e                   w_state_next;

    assign w_push_entry = '{data: in_data, row: in_row, col: in_col, index: in_index,
                            bypass: bypass_mode, channel: cur_channel};

`ifdef TRW_OVERFLOW_CHECK_EN
    logic w_range_err;
    logic r_overflow;

    assign w_range_err = !bypass_mode &&
                         (({1'b0, in_row} >= out_width) || ({1'b0, in_col} >= out_width));
    assign w_push_ok   = in_valid && !w_range_err && (!w_fifo_full || w_pop);
    assign overflow    = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (in_valid && (w_range_err || (w_fifo_full && !w_pop))) begin
            r_overflow <= 1'b1;
        end
    end
`else
    assign w_push_ok = in_valid && (!w_fifo_full || w_pop);
    assign overflow  = 1'b0;
`endif

    sync_fifo #(
        .WIDTH ($bits(trw_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Output register frees up either when empty or when its write is accepted this cycle.
    assign w_out_free = !r_ram_we || ram_ready;
    assign w_a_adv    = r_a_valid && w_out_free;
    assign w_pop      = !w_fifo_empty && (!r_a_valid || w_out_free);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_a_entry <= '0;
            r_a_pix   <= '0;
        end else if (w_pop) begin
            r_a_valid <= 1'b1;
            r_a_entry <= w_head;
            r_a_pix   <= ADDR_BITS'(w_head.row) * ADDR_BITS'(out_width) + ADDR_BITS'(w_head.col);
        end else if (w_a_adv) begin
            r_a_valid <= 1'b0;
        end
    end

    always_comb begin
        w_addr = '0;
        w_be   = 4'b0000;
        if (r_a_entry.bypass) begin
            w_addr = base_addr + ADDR_BITS'(r_a_entry.index >> 2);
            w_be   = 4'b0001 << r_a_entry.index[1:0];
        end else begin
            w_addr = base_addr + r_a_pix * ADDR_BITS'(num_channels >> 2)
                   + ADDR_BITS'(r_a_entry.channel >> 2);
            w_be   = 4'b0001 << r_a_entry.channel[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_be    <= '0;
        end else if (w_a_adv) begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= w_addr;
            r_ram_wdata <= {4{r_a_entry.data}};
            r_ram_be    <= w_be;
        end else if (ram_ready) begin
            r_ram_we    <= 1'b0;
        end
    end

    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_be    = r_ram_be;
    assign idle      = (w_fifo_count == '0) && !r_a_valid && !r_ram_we;

    // True when everything is empty once this cycle's handshake (if any) completes.
    assign w_drained = w_fifo_empty && !w_push_ok && !r_a_valid && (!r_ram_we || ram_ready);

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (layer_done) w_state_next = StArmed;
            StArmed: if (w_drained)  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign write_done = (r_state == StDone);

endmodule

// File: tb/tb_tensor_ram_writer.sv
// Self-checking bench for tensor_ram_writer: directed cases plus a randomized stream.
module tb_tensor_ram_writer;
    localparam int unsigned N_BITS    = 6;
    localparam int unsigned CH_BITS   = 7;
    localparam int unsigned IDX_BITS  = 6;
    localparam int unsigned ADDR_BITS = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic [7:0]           in_data = '0;
    logic [N_BITS-1:0]    in_row = '0;
    logic [N_BITS-1:0]    in_col = '0;
    logic [IDX_BITS-1:0]  in_index = '0;
    logic                 bypass_mode = 1'b0;
    logic [N_BITS:0]      out_width = 7'd8;
    logic [CH_BITS-1:0]   num_channels = 7'd8;
    logic [CH_BITS-1:0]   cur_channel = '0;
    logic [ADDR_BITS-1:0] base_addr = 16'h0100;
    logic                 layer_done = 1'b0;
    logic                 ram_we;
    logic                 ram_ready = 1'b1;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [31:0]          ram_wdata;
    logic [3:0]           ram_be;
    logic                 idle;
    logic                 write_done;
    logic                 overflow;

    tensor_ram_writer u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_row       (in_row),
        .in_col       (in_col),
        .in_index     (in_index),
        .bypass_mode  (bypass_mode),
        .out_width    (out_width),
        .num_channels (num_channels),
        .cur_channel  (cur_channel),
        .base_addr    (base_addr),
        .layer_done   (layer_done),
        .ram_we       (ram_we),
        .ram_ready    (ram_ready),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_be       (ram_be),
        .idle         (idle),
        .write_done   (write_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned be;
        int unsigned data;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_writes = 0;
    int   n_done = 0;
    int   done_cyc = -1;
    int   last_hs_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference address/lane from the layer geometry, modulo the address width.
    function automatic exp_t model(input bit byp, input int unsigned row, input int unsigned col,
                                   input int unsigned idx, input int unsigned ch,
                                   input int unsigned d8);
        exp_t e;
        int unsigned a;
        int unsigned lane;
        if (byp) begin
            a    = int'(base_addr) + idx / 4;
            lane = idx % 4;
        end else begin
            a    = int'(base_addr) + (row * int'(out_width) + col) * (int'(num_channels) / 4)
                 + ch / 4;
            lane = ch % 4;
        end
        e.addr = a % 65536;
        e.be   = 1 << lane;
        e.data = d8 * 32'h01010101;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (ram_we && ram_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", ram_addr, e.addr);
                    check("wr_be", ram_be, e.be);
                    check("wr_data", ram_wdata, e.data);
                end
                n_writes++;
                last_hs_cyc = cyc;
                hs_cyc.push_back(cyc);
            end
            if (write_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send(input bit byp, input int unsigned row, input int unsigned col,
                        input int unsigned idx, input int unsigned ch, input int unsigned d8,
                        input bit ld, input bit expect_write);
        in_valid    = 1'b1;
        bypass_mode = byp;
        in_row      = N_BITS'(row);
        in_col      = N_BITS'(col);
        in_index    = IDX_BITS'(idx);
        cur_channel = CH_BITS'(ch);
        in_data     = 8'(d8);
        layer_done  = ld;
        if (expect_write) exp_q.push_back(model(byp, row, col, idx, ch, d8));
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        layer_done = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_we(input int budget);
        int n = 0;
        @(negedge clk);
        while (!ram_we && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!ram_we) check("wait_we_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && idle) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_idle", idle, 1);
    endtask

    initial begin
        int writes0;
        int done0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_be", ram_be, 0);
        check("rst_done", write_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_idle", idle, 1);

        // Conv element with latency: visible on the third negedge after the push cycle.
        idle_cycle();
        send(0, 2, 3, 0, 5, 8'h7F, 0, 1);
        @(negedge clk);
        check("lat_t1", ram_we, 0);
        @(negedge clk);
        check("lat_t2", ram_we, 0);
        @(negedge clk);
        check("lat_t3", ram_we, 1);
        check("conv_addr", ram_addr, 16'h0127);
        check("conv_be", ram_be, 4'b0010);
        check("conv_data", ram_wdata, 32'h7F7F7F7F);
        drain(20);

        // Bypass element.
        idle_cycle();
        base_addr = 16'h0000;
        send(1, 0, 0, 13, 0, 8'hF0, 0, 1);
        wait_we(10);
        check("byp_addr", ram_addr, 3);
        check("byp_be", ram_be, 4'b0010);
        check("byp_data", ram_wdata, 32'hF0F0F0F0);
        drain(20);

        // Backpressure: six elements held for ten cycles, then released.
        idle_cycle();
        base_addr = 16'h0200;
        ram_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(0, i, i + 1, 0, i, 8'h10 + i, 0, 1);
        writes0 = n_writes;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_we", ram_we, 1);
            check("bp_hold_addr", ram_addr, exp_q[0].addr);
            check("bp_hold_be", ram_be, exp_q[0].be);
            check("bp_hold_data", ram_wdata, exp_q[0].data);
        end
        check("bp_no_write", n_writes - writes0, 0);
        check("bp_no_drop", exp_q.size(), 6);
        hs_cyc.delete();
        @(posedge clk);
        #1;
        ram_ready = 1'b1;
        drain(30);
        check("bp_writes", hs_cyc.size(), 6);
        if (hs_cyc.size() == 6) check("bp_back_to_back", hs_cyc[5] - hs_cyc[0], 5);

        // Completion: layer_done with the fourth element.
        idle_cycle();
        done0 = n_done;
        for (int i = 0; i < 4; i++) send(0, 1, i, 0, 2, 8'hA0 + i, i == 3, 1);
        drain(30);
        repeat (4) @(negedge clk);
        check("done_pulses", n_done - done0, 1);
        check("done_cycle", done_cyc, last_hs_cyc + 1);
        check("done_idle", idle, 1);
        @(posedge clk);
        #1;

        // Randomized stream with random layer geometry and random backpressure.
        out_width    = 7'(1 + $urandom_range(0, 63));
        num_channels = 7'(4 * (1 + $urandom_range(0, 15)));
        base_addr    = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            ram_ready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() < 8 && $urandom_range(0, 2) != 0) begin
                send($urandom_range(0, 1),
                     $urandom_range(0, int'(out_width) - 1),
                     $urandom_range(0, int'(out_width) - 1),
                     $urandom_range(0, 63),
                     $urandom_range(0, int'(num_channels) - 1),
                     $urandom_range(0, 255), 0, 1);
            end else begin
                idle_cycle();
            end
        end
        ram_ready = 1'b1;
        drain(40);
        check("rand_writes_seen", n_writes > 20, 1);

`ifdef TRW_OVERFLOW_CHECK_EN
        // Twelve pushes against a stalled RAM: only ten fit (FIFO + stage A + output).
        @(posedge clk);
        #1;
        out_width    = 7'd8;
        num_channels = 7'd8;
        base_addr    = 16'h0300;
        ram_ready    = 1'b0;
        for (int i = 0; i < 12; i++) send(0, 0, i % 8, 0, i % 8, i, 0, i < 10);
        writes0 = n_writes;
        @(posedge clk);
        #1;
        ram_ready = 1'b1;
        drain(40);
        check("ovf_writes", n_writes - writes0, 10);
        check("ovf_flag", overflow, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);
`endif

        // Reset with five elements queued behind a stalled RAM.
        @(posedge clk);
        #1;
        ram_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(0, 1, i, 0, 0, 8'h55, 0, 1);
        repeat (3) idle_cycle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_we", ram_we, 0);
        check("mid_rst_idle", idle, 1);
        writes0 = n_writes;
        @(posedge clk);
        #1;
        ram_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_rst_no_writes", n_writes - writes0, 0);
        check("mid_rst_idle_end", idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tensor_ram_writer.md
# tensor_ram_writer

Downstream stage of the STA controller. It accepts the controller's non-backpressurable 8-bit output stream (value plus row/col, or plus index in bypass mode) and buffers it in a small FIFO. It converts each element to a tensor-RAM word address and byte lane, and issues byte-enabled writes to the tensor RAM write port under a valid/ready handshake. It also signals layer-write completion to the layer controller.

## Interface
- `MAX_N`, 64: max feature-map dimension; `N_BITS = $clog2(MAX_N)`
- `MAX_NUM_CH`, 64: max channels per layer; `CH_BITS = $clog2(MAX_NUM_CH+1)`
- `MAX_BYPASS_IDX`, 64: max dense-layer output index; `BYPASS_IDX_BITS = $clog2(MAX_BYPASS_IDX)`
- `ADDR_BITS`, 16: tensor RAM word-address width
- `FIFO_DEPTH`, 8: input FIFO entries, power of two, ≥4

Ports:
- `clk`, in, 1: clock
- `reset`, in, 1: synchronous, active-high
- `in_valid`, in, 1: stream element valid; no ready (upstream cannot stall)
- `in_data`, in, 8: requantized value
- `in_row`, in, N_BITS: output row
- `in_col`, in, N_BITS: output col
- `in_index`, in, BYPASS_IDX_BITS: dense output index
- `bypass_mode`, in, 1: 1 = dense layer (use `in_index`); sampled per element at push
- `out_width`, in, N_BITS+1: output feature-map width; stable during a layer
- `num_channels`, in, CH_BITS: output channels of layer; multiple of 4; stable during a layer
- `cur_channel`, in, CH_BITS: channel produced by current STA pass; sampled per element at push
- `base_addr`, in, ADDR_BITS: word address of the output tensor; stable during a layer
- `layer_done`, in, 1: pulse, upstream has emitted the last element
- `ram_we`, out, 1: write request valid
- `ram_ready`, in, 1: RAM accepts the write this cycle
- `ram_addr`, out, ADDR_BITS: word address
- `ram_wdata`, out, 32: `in_data` replicated to all 4 byte lanes
- `ram_be`, out, 4: one-hot byte enable
- `idle`, out, 1: FIFO empty, pipeline empty, no write pending
- `write_done`, out, 1: one-cycle pulse, all elements of the layer written
- `overflow`, out, 1: sticky error (see Configuration)

## Operation
- Push: when `in_valid`=1, the element is stored in the FIFO together with `bypass_mode` and `cur_channel`.
- Stage A: pops the FIFO head whenever stage A is empty or advancing. It registers the entry and the partial product `row*out_width + col`.
- Output register computes the address and lane from stage A:
  - Conv: `addr = base_addr + pix*(num_channels>>2) + (cur_channel>>2)`; `be = 1 << cur_channel[1:0]`
  - Bypass: `addr = base_addr + (in_index>>2)`; `be = 1 << in_index[1:0]`
- Arithmetic: unsigned; products truncated to ADDR_BITS; no saturation.
- The output register holds `ram_we`/addr/data/be stable until `ram_ready`=1. It is refilled in the same cycle it is accepted.
- Completion FSM, states IDLE → ARMED → DONE → IDLE:
  - IDLE → ARMED on `layer_done`.
  - ARMED → DONE when FIFO, stage A and output register are all empty.
  - DONE: asserts `write_done` for one cycle, then returns to IDLE.
  - `layer_done` while ARMED is ignored.
- `idle` = FIFO empty & stage A empty & `ram_we`=0.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `ram_be`=0, `write_done`=0, `overflow`=0, `idle`=1. FIFO pointers and count are 0; FSM is in IDLE.
- Latency with empty pipeline and `ram_ready`=1: `in_valid` at cycle t → `ram_we`=1 at t+3.
- Throughput: 1 write/cycle while `ram_ready`=1.
- Full FIFO, push with no pop: element dropped, FIFO unchanged.
- Full FIFO, push and pop in the same cycle: push accepted.
- Empty FIFO, push: element is not poppable until the next cycle (no fall-through).
- `write_done` asserts ≥1 cycle after the last write handshake, never in the same cycle.
- `layer_done` on the same cycle as the last `in_valid`: that element is written before `write_done`.
- Reset mid-operation: all buffered and pending writes are discarded; `ram_we` drops in the next cycle.

## Configuration
- `TRW_OVERFLOW_CHECK_EN` defined: a dropped push sets `overflow`, which stays set until `reset`.
  - Additionally, in conv mode, any element with `in_row ≥ out_width` or `in_col ≥ out_width` sets `overflow` and is dropped (never written).
- Undefined: `overflow` is tied to 0, no range check is performed, and out-of-range elements are written with truncated addresses.

## Structure
- Shared package `sys_types` holds:
  - `trw_entry_t` struct: data, row, col, index, bypass, channel.
  - Completion FSM state enum.
- One sub-module: `sync_fifo` (parameterised width/depth; push/pop/full/empty/count). Everything else is inline in `tensor_ram_writer`.

## Test plan
- Conv write: out_width=8, num_channels=8, cur_channel=5, base_addr=0x100, element (row 2, col 3, data 0x7F) → at t+3 `ram_addr`=0x100+(19*2+1)=0x127, `ram_be`=4'b0010, `ram_wdata`=0x7F7F7F7F.
- Bypass: in_index=13, base_addr=0, data 0xF0 → `ram_addr`=3, `ram_be`=4'b0010.
- Backpressure: 6 consecutive elements with `ram_ready`=0 for 10 cycles → no drops, `ram_addr`/`ram_be`/`ram_wdata` stable while held; then 6 writes in order on consecutive cycles.
- Overflow (macro on): `ram_ready`=0, 12 consecutive pushes, FIFO_DEPTH=8 → exactly 10 writes after release (8 FIFO + stage A + output reg), `overflow`=1 until reset.
- Completion: 4 elements, `layer_done` with the last one → `write_done` pulses once, 1 cycle after the 4th handshake; `idle`=1 afterwards.
- Reset mid-stream with 5 elements queued → `ram_we`=0 the next cycle, `idle`=1, no further writes.
